// File: rtl/lzc_seq_pkg.sv
// Shared types for the sequential leading-zero counter.
package lzc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk index width; a single-chunk configuration still needs one bit.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/lzc_seq_chunk.sv
// Combinational priority encoder for one chunk: index of the highest set bit.
module lzc_chunk #(
    parameter int unsigned CHUNK = 32,
    localparam int unsigned CLOG = $clog2(CHUNK)
) (
    input  logic [CHUNK-1:0] i_data,
    output logic [CLOG-1:0]  o_idx,
    output logic             o_nz
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        o_nz  = |i_data;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (i_data[i]) begin
                o_idx = CLOG'(i);
            end
        end
    end

endmodule

// File: rtl/lzc_seq.sv
// Sequential leading-zero counter: scans the operand CHUNK bits per cycle,
// most-significant chunk first, and reports the highest set bit position.
// Build option: LZC_EARLY_EXIT_EN -- leave the scan on the first non-zero
// chunk instead of always scanning all NCHUNK chunks.
module lzc_seq
    import lzc_seq_pkg::*;
#(
    parameter int unsigned XLEN  = 256,
    parameter int unsigned CHUNK = 32,
    localparam int unsigned XLOG   = $clog2(XLEN),
    localparam int unsigned NCHUNK = XLEN / CHUNK
) (
    input  logic            reset,
    input  logic            clock,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLOG-1:0] out_pos,
    output logic [XLOG:0]   out_zcnt,
    output logic            out_nz
);

    localparam int unsigned    CLOG      = $clog2(CHUNK);
    localparam int unsigned    IW        = idx_width(NCHUNK);
    localparam logic [IW-1:0]  IDX_TOP   = IW'(NCHUNK - 1);
    localparam logic [XLOG:0]  ZCNT_MAX  = (XLOG + 1)'(XLEN - 1);
    localparam logic [XLOG:0]  ZCNT_ZERO = (XLOG + 1)'(XLEN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [XLEN-1:0]  r_data;
    logic [IW-1:0]    r_idx;
    logic             r_hit;
    logic [XLOG-1:0]  r_pos;
    logic [XLOG:0]    r_zcnt;
    logic             r_nz;

    logic [XLOG-1:0]  w_base;
    logic [XLOG-1:0]  w_pos;
    logic [CHUNK-1:0] w_chunk;
    logic [CLOG-1:0]  w_lidx;
    logic             w_lnz;
    logic             w_accept;
    logic             w_scan_end;

    // Chunk base is idx*CHUNK; CHUNK is a power of two so this is a shift.
    assign w_base  = XLOG'({r_idx, {CLOG{1'b0}}});
    assign w_chunk = r_data[w_base +: CHUNK];
    assign w_pos   = w_base | XLOG'(w_lidx);

    lzc_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_data (w_chunk),
        .o_idx  (w_lidx),
        .o_nz   (w_lnz)
    );

`ifdef LZC_EARLY_EXIT_EN
    assign w_scan_end = w_lnz | (r_idx == '0);
`else
    assign w_scan_end = (r_idx == '0);
`endif

    assign w_accept = in_valid & in_ready;

    assign out_pos  = r_pos;
    assign out_zcnt = r_zcnt;
    assign out_nz   = r_nz;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; DONE can hand straight back to SCAN.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_scan_end) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    w_state_nxt = in_valid ? SCAN : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and scan datapath; the zero-operand result is preloaded
    // on accept so an all-zero scan needs no extra write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_idx  <= '0;
            r_hit  <= 1'b0;
            r_pos  <= '0;
            r_zcnt <= '0;
            r_nz   <= 1'b0;
        end else if (w_accept) begin
            r_data <= in_data;
            r_idx  <= IDX_TOP;
            r_hit  <= 1'b0;
            r_pos  <= '0;
            r_zcnt <= ZCNT_ZERO;
            r_nz   <= 1'b0;
        end else if (r_state == SCAN) begin
            if (r_idx != '0) begin
                r_idx <= r_idx - IW'(1);
            end
            if (w_lnz && !r_hit) begin
                r_hit  <= 1'b1;
                r_pos  <= w_pos;
                r_zcnt <= ZCNT_MAX - {1'b0, w_pos};
                r_nz   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/lzc_seq.md
LZC_SEQ -- requirements
Module: lzc_seq

Interface
REQ-001 SHALL have parameter XLEN, default 256, input width in bits; a power of two, 8..1024.
REQ-002 SHALL have parameter CHUNK, default 32, bits examined per scan cycle; a power of two, 4..XLEN.
REQ-003 SHALL have derived constants XLOG = clog2(XLEN) and NCHUNK = XLEN/CHUNK.
REQ-004 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-005 SHALL have port clock  in  1  rising-edge clock.
REQ-006 SHALL have port in_valid  in  1  operand offered.
REQ-007 SHALL have port in_ready  out  1  operand accepted when high with in_valid.
REQ-008 SHALL have port in_data  in  XLEN  operand.
REQ-009 SHALL have port out_valid  out  1  result available.
REQ-010 SHALL have port out_ready  in  1  consumer takes result.
REQ-011 SHALL have port out_pos  out  XLOG  index of most-significant set bit.
REQ-012 SHALL have port out_zcnt  out  XLOG+1  leading-zero count, XLEN when operand is zero.
REQ-013 SHALL have port out_nz  out  1  operand non-zero.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-015 IDLE SHALL drive in_ready=1; on in_valid it SHALL register in_data, set chunk index idx=NCHUNK-1 and go to SCAN.
REQ-016 SCAN SHALL examine bits [idx*CHUNK +: CHUNK] each cycle, most-significant chunk first.
REQ-017 The first non-zero chunk SHALL set out_pos = idx*CHUNK + local index, out_zcnt = XLEN-1-out_pos and out_nz=1.
REQ-018 If every chunk is zero, the block SHALL set out_nz=0, out_pos=0 and out_zcnt=XLEN.
REQ-019 idx SHALL decrement each SCAN cycle, never wrap below 0, and leave SCAN after the idx=0 chunk at the latest.
REQ-020 DONE SHALL drive out_valid=1 and hold out_pos, out_zcnt and out_nz stable until out_ready is sampled high.
REQ-021 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready).
REQ-022 When an output handshake and an input handshake occur in the same DONE cycle, the block SHALL go directly to SCAN with the new operand.
REQ-023 An output handshake without a new operand SHALL return the FSM to IDLE.
REQ-024 in_ready and out_valid SHALL be 0 in SCAN.
REQ-025 in_data SHALL be ignored outside accepting handshakes.

Reset
REQ-026 Reset low SHALL immediately force IDLE, in_ready=1, out_valid=0, out_pos=0, out_zcnt=0, out_nz=0 and idx=0.
REQ-027 Reset asserted mid-SCAN or mid-DONE SHALL discard the operand with no result emitted.

Configuration
REQ-028 With LZC_EARLY_EXIT_EN defined, SCAN SHALL exit to DONE on the first non-zero chunk, giving out_valid m cycles after the accepting edge, where m = chunks examined (1..NCHUNK).
REQ-029 Without LZC_EARLY_EXIT_EN, SCAN SHALL always examine all NCHUNK chunks and keep the first (highest) hit, giving fixed latency NCHUNK.

Structure
REQ-030 The state enum typedef SHALL live in shared package lzc_seq_pkg.
REQ-031 The per-chunk priority encoder SHALL be sub-module lzc_chunk (parameter CHUNK; outputs local index and non-zero flag, combinational).
REQ-032 The total RTL SHALL be 120-400 lines.

Verification (XLEN=256, CHUNK=32)
REQ-033 Bench SHALL drive in_data=1<<255 and see out_pos=255, out_zcnt=0, out_nz=1, with latency 1 (early exit) or 8 (fixed).
REQ-034 Bench SHALL drive in_data=1 and see out_pos=0, out_zcnt=255, out_nz=1, latency 8 in both modes.
REQ-035 Bench SHALL drive in_data=0 and see out_nz=0, out_pos=0, out_zcnt=256, latency 8.
REQ-036 Bench SHALL sweep a walking one over bits 0..255 plus 1000 random operands and see out_pos match the reference model on each.
REQ-037 Bench SHALL hold out_ready=0 for 5 cycles in DONE and see outputs stable and in_ready=0; it SHALL then raise out_ready and in_valid together and see a same-cycle re-accept into SCAN.
REQ-038 Bench SHALL pull reset low in SCAN cycle 3 and see out_valid=0 at once and in_ready=1; the next operand after release SHALL produce a correct result.
